rr_grant_arb: RTL and testbench

- Registered round-robin arbiter stage that consumes the one-hot first-one pick and owns the grant handshake toward the shared resource.
- Arbitration is combinational: the request vector is rotated by a priority pointer, a first-one pick is taken, and the result is un-rotated.
- The stage registers the result as a one-hot grant plus index. It holds the grant across multi-beat transfers until the last beat is accepted.
- Pointer update gives fairness; a drop of the granted request before its last beat aborts the transfer.

---
 rtl/arb_pkg.sv | 74 +++++++
 rtl/rr_rot_pick.sv | 63 ++++++
 rtl/rr_grant_arb.sv | 182 ++++++++++++++++++
 tb/tb_rr_grant_arb.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin grant arbiter: FSM state encoding,
// rotate/one-hot helpers over a fixed-width container, and default constants.
package arb_pkg;

   localparam int ARB_N_DEF   = 8;
   localparam int ARB_TMO_DEF = 16;

   // Helpers work on a fixed container; callers zero-extend and size-cast back to N bits
   localparam int ARB_NMAX = 64;
   localparam int ARB_IDXW = 6;

   typedef enum logic [0:0] {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_e;

   // Rotate the low n bits right by amt (amt < n): r[i] = v[(i + amt) mod n]
   function automatic logic [ARB_NMAX-1:0] arb_rotr(input logic [ARB_NMAX-1:0] v,
                                                     input int amt, input int n);
      logic [ARB_NMAX-1:0] r;
      int j;
      r = {ARB_NMAX{1'b0}};
      for (int i = 0; i < ARB_NMAX; i++) begin
         j = i + amt;
         if (j >= n) begin
            j = j - n;
         end else begin
            j = j;
         end
         if (i < n) begin
            r[i] = v[j[ARB_IDXW-1:0]];
         end else begin
            r[i] = 1'b0;
         end
      end
      return r;
   endfunction

   // Rotate the low n bits left by amt (amt < n): r[(i + amt) mod n] = v[i]
   function automatic logic [ARB_NMAX-1:0] arb_rotl(input logic [ARB_NMAX-1:0] v,
                                                     input int amt, input int n);
      logic [ARB_NMAX-1:0] r;
      int j;
      r = {ARB_NMAX{1'b0}};
      for (int i = 0; i < ARB_NMAX; i++) begin
         j = i + amt;
         if (j >= n) begin
            j = j - n;
         end else begin
            j = j;
         end
         if (i < n) begin
            r[j[ARB_IDXW-1:0]] = v[i];
         end else begin
            r = r;
         end
      end
      return r;
   endfunction

   function automatic logic [ARB_IDXW-1:0] arb_oh2idx(input logic [ARB_NMAX-1:0] v);
      logic [ARB_IDXW-1:0] idx;
      idx = {ARB_IDXW{1'b0}};
      for (int i = 0; i < ARB_NMAX; i++) begin
         if (v[i]) begin
            idx = idx | ARB_IDXW'(i);
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_rot_pick.sv
// Combinational round-robin pick: rotate req so the pointer lands at the search
// origin, take the first set bit in the search direction, rotate back.
module rr_rot_pick
   import arb_pkg::*;
#(
   parameter int N  = ARB_N_DEF,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   input  logic          msb_first,
   output logic [N-1:0]  win,
   output logic          found
);

   int                  amt_s;
   logic [ARB_NMAX-1:0] rot_s;
   logic [ARB_NMAX-1:0] sel_s;
   logic [ARB_NMAX-1:0] win_pad_s;
   logic                hit_s;

   // Descending search puts ptr at the top bit and takes the highest set bit
   always_comb begin
      amt_s = 0;
      if (msb_first) begin
         if (ptr == IW'(N-1)) begin
            amt_s = 0;
         end else begin
            amt_s = int'(ptr) + 1;
         end
      end else begin
         amt_s = int'(ptr);
      end

      rot_s = arb_rotr(ARB_NMAX'(req), amt_s, N);
      sel_s = {ARB_NMAX{1'b0}};
      hit_s = 1'b0;
      if (msb_first) begin
         for (int i = ARB_NMAX-1; i >= 0; i--) begin
            if ((i < N) && rot_s[i] && !hit_s) begin
               sel_s[i] = 1'b1;
               hit_s    = 1'b1;
            end else begin
               hit_s = hit_s;
            end
         end
      end else begin
         for (int i = 0; i < ARB_NMAX; i++) begin
            if ((i < N) && rot_s[i] && !hit_s) begin
               sel_s[i] = 1'b1;
               hit_s    = 1'b1;
            end else begin
               hit_s = hit_s;
            end
         end
      end

      win_pad_s = arb_rotl(sel_s, amt_s, N);
      win       = N'(win_pad_s);
      found     = |req;
   end

endmodule

// File: rtl/rr_grant_arb.sv
// Registered round-robin grant stage with multi-beat hold, abort on request drop
// and an optional stall timeout enabled by the ARB_TIMEOUT_EN macro.
module rr_grant_arb
   import arb_pkg::*;
#(
   parameter int N         = ARB_N_DEF,
   parameter int IW        = $clog2(N),
   parameter int MSB_FIRST = 0,
   parameter int TMO       = ARB_TMO_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  req,
   input  logic [N-1:0]  req_last,
   input  logic          gnt_ready,
   output logic          gnt_valid,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_idx,
   output logic          gnt_abort,
   output logic          gnt_tmo
);

   localparam logic DIR = (MSB_FIRST != 0) ? 1'b1 : 1'b0;

   arb_state_e    state_q, state_d;
   logic [N-1:0]  gnt_q, gnt_d;
   logic [IW-1:0] gnt_idx_q, gnt_idx_d;
   logic [IW-1:0] ptr_q, ptr_d;
   logic          abort_q, abort_d;

   logic [IW-1:0] adv_ptr_s;
   logic [IW-1:0] pick_ptr_s;
   logic [N-1:0]  pick_req_s;
   logic [N-1:0]  win_s;
   logic [IW-1:0] win_idx_s;
   logic          found_s;
   logic          cur_req_s;
   logic          cur_last_s;
   logic          tmo_hit_s;

   // While busy the picker already looks at the post-completion pointer and masked req
   always_comb begin
      cur_req_s  = req[gnt_idx_q];
      cur_last_s = req_last[gnt_idx_q];
      if (DIR) begin
         if (gnt_idx_q == {IW{1'b0}}) begin
            adv_ptr_s = IW'(N-1);
         end else begin
            adv_ptr_s = gnt_idx_q - IW'(1);
         end
      end else begin
         if (gnt_idx_q == IW'(N-1)) begin
            adv_ptr_s = {IW{1'b0}};
         end else begin
            adv_ptr_s = gnt_idx_q + IW'(1);
         end
      end
      if (state_q == ARB_BUSY) begin
         pick_ptr_s = adv_ptr_s;
         pick_req_s = req & ~gnt_q;
      end else begin
         pick_ptr_s = ptr_q;
         pick_req_s = req;
      end
      win_idx_s = IW'(arb_oh2idx(ARB_NMAX'(win_s)));
   end

   rr_rot_pick #(
      .N  (N),
      .IW (IW)
   ) u_pick (
      .req       (pick_req_s),
      .ptr       (pick_ptr_s),
      .msb_first (DIR),
      .win       (win_s),
      .found     (found_s)
   );

   // Next-state: abort and timeout release without re-pick; completion re-picks same cycle
   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      gnt_idx_d = gnt_idx_q;
      ptr_d     = ptr_q;
      abort_d   = 1'b0;
      case (state_q)
         ARB_IDLE: begin
            if (found_s) begin
               state_d   = ARB_BUSY;
               gnt_d     = win_s;
               gnt_idx_d = win_idx_s;
            end else begin
               gnt_d     = {N{1'b0}};
               gnt_idx_d = {IW{1'b0}};
            end
         end
         ARB_BUSY: begin
            if (!cur_req_s || tmo_hit_s) begin
               abort_d   = !cur_req_s;
               ptr_d     = adv_ptr_s;
               state_d   = ARB_IDLE;
               gnt_d     = {N{1'b0}};
               gnt_idx_d = {IW{1'b0}};
            end else if (gnt_ready && cur_last_s) begin
               ptr_d = adv_ptr_s;
               if (found_s) begin
                  gnt_d     = win_s;
                  gnt_idx_d = win_idx_s;
               end else begin
                  state_d   = ARB_IDLE;
                  gnt_d     = {N{1'b0}};
                  gnt_idx_d = {IW{1'b0}};
               end
            end else begin
               state_d = ARB_BUSY;
            end
         end
         default: begin
            state_d   = ARB_IDLE;
            gnt_d     = {N{1'b0}};
            gnt_idx_d = {IW{1'b0}};
         end
      endcase
   end

   // Arbiter state registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ARB_IDLE;
         gnt_q     <= {N{1'b0}};
         gnt_idx_q <= {IW{1'b0}};
         ptr_q     <= {IW{1'b0}};
         abort_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         gnt_idx_q <= gnt_idx_d;
         ptr_q     <= ptr_d;
         abort_q   <= abort_d;
      end
   end

`ifdef ARB_TIMEOUT_EN
   localparam int CW = $clog2(TMO+1);

   logic [CW-1:0] tcnt_q, tcnt_d;
   logic          tmo_q, tmo_d;

   // Fire one cycle early so the release lands after exactly TMO stalled busy cycles
   always_comb begin
      tmo_hit_s = (state_q == ARB_BUSY) && !gnt_ready && (tcnt_q == CW'(TMO-1));
      tmo_d     = tmo_hit_s && cur_req_s;
      if ((state_q == ARB_BUSY) && (state_d == ARB_BUSY) && !gnt_ready) begin
         tcnt_d = tcnt_q + CW'(1);
      end else begin
         tcnt_d = {CW{1'b0}};
      end
   end

   // Timeout counter and pulse registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tcnt_q <= {CW{1'b0}};
         tmo_q  <= 1'b0;
      end else begin
         tcnt_q <= tcnt_d;
         tmo_q  <= tmo_d;
      end
   end

   assign gnt_tmo = tmo_q;
`else
   assign tmo_hit_s = 1'b0;
   assign gnt_tmo   = 1'b0;
`endif

   assign gnt_valid = (state_q == ARB_BUSY);
   assign gnt       = gnt_q;
   assign gnt_idx   = gnt_idx_q;
   assign gnt_abort = abort_q;

endmodule

// File: tb/tb_rr_grant_arb.sv
// Scoreboard bench for rr_grant_arb: one ascending and one descending instance,
// directed per-cycle vectors with hand-computed expected grants.
module tb_rr_grant_arb;

   logic       clk = 1'b0;
   logic       rst_a, rst_d;
   logic [7:0] req, req_last;
   logic       gnt_ready;

   logic       gv_a, ab_a, tm_a;
   logic [7:0] gnt_a;
   logic [2:0] gi_a;
   logic       gv_d, ab_d, tm_d;
   logic [7:0] gnt_d;
   logic [2:0] gi_d;

   typedef struct packed {
      logic       va;
      logic [2:0] ia;
      logic       aa;
      logic       ta;
      logic       vd;
      logic [2:0] id;
      logic       ad;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   rr_grant_arb #(.N(8), .IW(3), .MSB_FIRST(0), .TMO(16)) dut (
      .clk(clk), .rst(rst_a), .req(req), .req_last(req_last), .gnt_ready(gnt_ready),
      .gnt_valid(gv_a), .gnt(gnt_a), .gnt_idx(gi_a), .gnt_abort(ab_a), .gnt_tmo(tm_a)
   );

   rr_grant_arb #(.N(8), .IW(3), .MSB_FIRST(1), .TMO(16)) dut_desc (
      .clk(clk), .rst(rst_d), .req(req), .req_last(req_last), .gnt_ready(gnt_ready),
      .gnt_valid(gv_d), .gnt(gnt_d), .gnt_idx(gi_d), .gnt_abort(ab_d), .gnt_tmo(tm_d)
   );

   function automatic exp_t ea(input logic va, input logic [2:0] ia, input logic aa, input logic ta);
      exp_t x;
      x = '0;
      x.va = va; x.ia = ia; x.aa = aa; x.ta = ta;
      return x;
   endfunction

   function automatic exp_t ed(input logic vd, input logic [2:0] id, input logic ad);
      exp_t x;
      x = '0;
      x.vd = vd; x.id = id; x.ad = ad;
      return x;
   endfunction

   function automatic logic [7:0] onehot(input logic v, input logic [2:0] i);
      logic [7:0] one;
      one = 8'd1;
      return v ? (one << i) : 8'd0;
   endfunction

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s t=%0t actual=%0h required=%0h", nm, $time, act, exp);
      end
   endtask

   task automatic step(input logic [7:0] r, input logic [7:0] l, input logic rdy, input exp_t x);
      req       = r;
      req_last  = l;
      gnt_ready = rdy;
      @(posedge clk);
      sb.push_back(x);
      @(negedge clk);
   endtask

   // Monitor: pop the expectation for the cycle just clocked and compare both instances
   initial begin
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("asc_valid", {7'd0, gv_a}, {7'd0, e.va});
            chk("asc_idx",   {5'd0, gi_a}, {5'd0, e.ia});
            chk("asc_gnt",   gnt_a, onehot(e.va, e.ia));
            chk("asc_abort", {7'd0, ab_a}, {7'd0, e.aa});
            chk("asc_tmo",   {7'd0, tm_a}, {7'd0, e.ta});
            chk("desc_valid", {7'd0, gv_d}, {7'd0, e.vd});
            chk("desc_idx",   {5'd0, gi_d}, {5'd0, e.id});
            chk("desc_gnt",   gnt_d, onehot(e.vd, e.id));
            chk("desc_abort", {7'd0, ab_d}, {7'd0, e.ad});
            chk("desc_tmo",   {7'd0, tm_d}, {7'd0, 1'b0});
         end
      end
   end

   initial begin
      rst_a = 1'b1; rst_d = 1'b1;
      req = 8'hFF; req_last = 8'hFF; gnt_ready = 1'b1;
      @(negedge clk);
      step(8'hFF, 8'hFF, 1'b1, ea(1'b0, 3'd0, 1'b0, 1'b0));
      step(8'hFF, 8'hFF, 1'b1, ea(1'b0, 3'd0, 1'b0, 1'b0));
      rst_a = 1'b0;

      // full round robin, back-to-back with wrap 7 -> 0
      step(8'hFF, 8'hFF, 1'b1, ea(1'b1, 3'd0, 1'b0, 1'b0));
      for (int i = 1; i <= 8; i++) step(8'hFF, 8'hFF, 1'b1, ea(1'b1, 3'(i % 8), 1'b0, 1'b0));
      step(8'h01, 8'hFF, 1'b1, ea(1'b0, 3'd0, 1'b0, 1'b0));

      // move ptr to 5, then req bits 0 and 5
      step(8'h10, 8'hFF, 1'b0, ea(1'b1, 3'd4, 1'b0, 1'b0));
      step(8'h10, 8'hFF, 1'b1, ea(1'b0, 3'd0, 1'b0, 1'b0));
      step(8'h21, 8'hFF, 1'b0, ea(1'b1, 3'd5, 1'b0, 1'b0));
      step(8'h21, 8'hFF, 1'b1, ea(1'b1, 3'd0, 1'b0, 1'b0));
      step(8'h21, 8'hFF, 1'b1, ea(1'b1, 3'd5, 1'b0, 1'b0));
      step(8'h20, 8'hFF, 1'b1, ea(1'b0, 3'd0, 1'b0, 1'b0));

      // multi-beat hold on idx 2 with a stall, then ptr must be 3
      step(8'h04, 8'h00, 1'b1, ea(1'b1, 3'd2, 1'b0, 1'b0));
      for (int i = 0; i < 3; i++) step(8'h04, 8'h00, 1'b1, ea(1'b1, 3'd2, 1'b0, 1'b0));
      step(8'h04, 8'h04, 1'b0, ea(1'b1, 3'd2, 1'b0, 1'b0));
      step(8'h04, 8'h04, 1'b1, ea(1'b0, 3'd0, 1'b0, 1'b0));
      step(8'h0C, 8'hFF, 1'b0, ea(1'b1, 3'd3, 1'b0, 1'b0));
      step(8'h0C, 8'hFF, 1'b1, ea(1'b1, 3'd2, 1'b0, 1'b0));

      // abort of idx 2, next grant from 3; non-granted changes ignored; abort beats completion
      step(8'h08, 8'h00, 1'b0, ea(1'b0, 3'd0, 1'b1, 1'b0));
      step(8'h0C, 8'h00, 1'b0, ea(1'b1, 3'd3, 1'b0, 1'b0));
      step(8'hFF, 8'h00, 1'b0, ea(1'b1, 3'd3, 1'b0, 1'b0));
      step(8'hF4, 8'hFF, 1'b1, ea(1'b0, 3'd0, 1'b1, 1'b0));
      step(8'h00, 8'hFF, 1'b0, ea(1'b0, 3'd0, 1'b0, 1'b0));

      // long stall on idx 6 (ptr 4)
      step(8'h48, 8'hFF, 1'b0, ea(1'b1, 3'd6, 1'b0, 1'b0));
      for (int s = 1; s <= 17; s++) begin
`ifdef ARB_TIMEOUT_EN
         if (s < 16)       step(8'h48, 8'hFF, 1'b0, ea(1'b1, 3'd6, 1'b0, 1'b0));
         else if (s == 16) step(8'h48, 8'hFF, 1'b0, ea(1'b0, 3'd0, 1'b0, 1'b1));
         else              step(8'h48, 8'hFF, 1'b0, ea(1'b1, 3'd3, 1'b0, 1'b0));
`else
         step(8'h48, 8'hFF, 1'b0, ea(1'b1, 3'd6, 1'b0, 1'b0));
`endif
      end
      step(8'h00, 8'hFF, 1'b0, ea(1'b0, 3'd0, 1'b1, 1'b0));
      step(8'h00, 8'hFF, 1'b0, ea(1'b0, 3'd0, 1'b0, 1'b0));

      // descending instance: reach ptr 3, then req bits 0 and 5 with 0 -> 7 wrap
      rst_a = 1'b1; rst_d = 1'b0;
      step(8'h10, 8'hFF, 1'b0, ed(1'b1, 3'd4, 1'b0));
      step(8'h10, 8'hFF, 1'b1, ed(1'b0, 3'd0, 1'b0));
      step(8'h21, 8'hFF, 1'b0, ed(1'b1, 3'd0, 1'b0));
      step(8'h21, 8'hFF, 1'b1, ed(1'b1, 3'd5, 1'b0));
      step(8'h21, 8'hFF, 1'b1, ed(1'b1, 3'd0, 1'b0));
      step(8'h00, 8'hFF, 1'b1, ed(1'b0, 3'd0, 1'b1));
      step(8'h00, 8'hFF, 1'b1, ed(1'b0, 3'd0, 1'b0));

      for (int k = 0; k < 4 && sb.size() > 0; k++) @(negedge clk);
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL drain left=%0d required=0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
